reg_file_wb: RTL
================

Name: reg_file_wb

Overview:
- 32 x 64-bit LEGv8 register file; this is the receiving end of the write-back path.
- It accepts w_data and its destination from the write-back stage and serves two combinational read ports to the decode stage.
- It includes a write-through bypass and a per-register pending-write scoreboard, which drives a decode stall for read-after-write hazards.
- It sits between the write-back stage (producer of w_data) and the instruction decode stage (consumer of r_data1/r_data2).

Parameters:
- WORD, 64, data width of each register.
- REG_NUM, 32, number of architectural registers.
- ADDR_W, 5, register index width; must equal log2(REG_NUM).
- XZR_IDX, 31, index hardwired to zero.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- rd_addr1  input  ADDR_W  read port 1 index (Rn).
- rd_addr2  input  ADDR_W  read port 2 index (Rm/Rt).
- rd_use1  input  1  decode uses read port 1 this cycle.
- rd_use2  input  1  decode uses read port 2 this cycle.
- r_data1  output  WORD  read port 1 data.
- r_data2  output  WORD  read port 2 data.
- RegWrite  input  1  write-back write enable.
- w_addr  input  ADDR_W  write-back destination index.
- w_data  input  WORD  write-back data.
- issue_valid  input  1  decode issues a register-writing instruction this cycle.
- issue_rd  input  ADDR_W  destination of the issued instruction.
- stall  output  1  decode must hold; operand still pending.
- busy_mask  output  REG_NUM  scoreboard bits, bit i = register i pending.
- pend_cnt  output  6  number of set busy bits.

Behaviour:
- Reset: the design has one clock and an asynchronous, active-low reset. When rst_n is asserted:
  - all registers clear to 0
  - busy_mask = 0
  - pend_cnt = 0
  - stall = 0
  - r_data1/r_data2 = 0 for any index.
  Reset mid-operation discards all pending writes and scoreboard state immediately, without waiting for a clock.
- Write:
  - On posedge clk with RegWrite=1 and w_addr != XZR_IDX, regs[w_addr] <= w_data.
  - Writes to XZR_IDX are dropped.
  - Write latency is 1 cycle to the array.
- Read:
  - Combinational, with no clock latency.
  - Index XZR_IDX always returns 0, even when being written.
  - Bypass: if RegWrite=1, w_addr == rd_addrN and w_addr != XZR_IDX, then r_dataN = w_data in the same cycle. Otherwise r_dataN = regs[rd_addrN].
- Scoreboard, evaluated per register i each posedge:
  - set_i = issue_valid && issue_rd==i && i!=XZR_IDX.
  - clr_i = RegWrite && w_addr==i && i!=XZR_IDX.
  - set_i=1: busy[i] <= 1. Set wins over a simultaneous clr_i, because the new producer is younger.
  - else clr_i=1: busy[i] <= 0.
  - else busy[i] holds.
  - Clearing a register that is not busy is legal and a no-op.
- pend_cnt: registered population count of busy_mask. It updates on the same edge as busy_mask, so it always equals popcount(busy_mask). Maximum value is 31.
- stall: combinational.
  - stall = (rd_use1 && hazard(rd_addr1)) || (rd_use2 && hazard(rd_addr2)).
  - hazard(a) = busy[a] && a != XZR_IDX && !(RegWrite && w_addr==a).
  - An operand being written back this cycle is covered by the bypass and does not stall.
- While stall=1, the decoder holds issue_valid=0. The block does not gate issue_valid itself; an issue presented during stall is still recorded.
- Unused read ports (rd_useN=0) never stall.

Test Plan:
- Reset:
  - Drive rst_n=0 asynchronously mid-cycle after writing X3=0x1234 and issuing X5.
  - Require r_data1(X3)=0, busy_mask=0, pend_cnt=0 and stall=0 before the next clk edge.
- Write/read:
  - Write X7=100 (RegWrite=1, w_addr=7).
  - Next cycle read rd_addr1=7 -> r_data1=100.
  - Write X31=55 and read X31 -> r_data2=0, same cycle and after.
- Bypass:
  - Same cycle RegWrite=1, w_addr=9, w_data=200, rd_addr1=9, with X9 previously 90 -> r_data1=200 combinationally.
  - Next cycle r_data1=200 from the array.
- RAW stall:
  - issue_valid=1, issue_rd=4 -> busy_mask=0x10, pend_cnt=1.
  - rd_addr2=4, rd_use2=1 -> stall=1 for 3 idle cycles.
  - Write-back cycle w_addr=4 -> stall=0 in that cycle, r_data2=w_data.
  - Next cycle busy_mask=0.
- Simultaneous set/clear:
  - X6 busy; in the same cycle RegWrite w_addr=6 and issue_valid issue_rd=6.
  - Require busy[6]=1 after the edge, pend_cnt unchanged at 1, and X6 updated to w_data.
- Count/XZR:
  - Issue X0..X30 on consecutive cycles -> pend_cnt=31.
  - Issue X31 -> pend_cnt stays 31 and busy_mask[31]=0.
  - rd_use1=1 with rd_addr1=31 -> stall=0.

Source files
------------

// File: rtl/reg_file_wb.sv
// ---------------------------------------------------------------------------
// reg_file_wb
//   32 x 64-bit LEGv8 register file that receives the write-back path. It
//   serves two combinational read ports to decode. A write-back in flight
//   bypasses straight to a read port. A per-register pending-write scoreboard
//   raises a decode stall for read-after-write hazards.
//
// Ports
//   clk, rst_n            clock (rising edge), async active-low reset
//   rd_addr1/2, rd_use1/2 decode read indices and "operand used" qualifiers
//   r_data1/2             combinational read data (XZR always reads 0)
//   RegWrite, w_addr,     write-back enable, destination and data
//   w_data
//   issue_valid, issue_rd decode issues a register-writing instruction
//   stall                 decode must hold, because an operand is pending
//   busy_mask             scoreboard, bit i set = register i pending
//   pend_cnt              registered population count of busy_mask
// ---------------------------------------------------------------------------
module reg_file_wb #(
  parameter int WORD    = 64,
  parameter int REG_NUM = 32,
  parameter int ADDR_W  = 5,
  parameter int XZR_IDX = 31
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [ADDR_W-1:0]  rd_addr1,
  input  logic [ADDR_W-1:0]  rd_addr2,
  input  logic               rd_use1,
  input  logic               rd_use2,
  output logic [WORD-1:0]    r_data1,
  output logic [WORD-1:0]    r_data2,
  input  logic               RegWrite,
  input  logic [ADDR_W-1:0]  w_addr,
  input  logic [WORD-1:0]    w_data,
  input  logic               issue_valid,
  input  logic [ADDR_W-1:0]  issue_rd,
  output logic               stall,
  output logic [REG_NUM-1:0] busy_mask,
  output logic [5:0]         pend_cnt
);

  localparam logic [ADDR_W-1:0] XZR = ADDR_W'(XZR_IDX);

  logic [WORD-1:0]    regs [REG_NUM];
  logic [REG_NUM-1:0] busy;
  logic [REG_NUM-1:0] busy_nxt;
  logic [5:0]         cnt_nxt;
  logic               wr_en;

  // Writes to XZR are dropped everywhere, including bypass and scoreboard.
  assign wr_en = RegWrite && (w_addr != XZR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < REG_NUM; i++) regs[i] <= '0;
    end else if (wr_en) begin
      regs[w_addr] <= w_data;
    end
  end

  // A younger issue to the same register wins over its older write-back.
  always_comb begin
    busy_nxt = busy;
    for (int i = 0; i < REG_NUM; i++) begin
      if (i != XZR_IDX) begin
        if (issue_valid && issue_rd == ADDR_W'(i))
          busy_nxt[i] = 1'b1;
        else if (wr_en && w_addr == ADDR_W'(i))
          busy_nxt[i] = 1'b0;
      end
    end
    cnt_nxt = '0;
    for (int i = 0; i < REG_NUM; i++) cnt_nxt = cnt_nxt + 6'(busy_nxt[i]);
  end

  // The count is taken from the next-state mask so that it tracks busy_mask
  // on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy     <= '0;
      pend_cnt <= '0;
    end else begin
      busy     <= busy_nxt;
      pend_cnt <= cnt_nxt;
    end
  end

  assign busy_mask = busy;

  // Reads are forced to zero while reset is held, so that a bypassed
  // w_data cannot leak out.
  always_comb begin
    r_data1 = '0;
    if (rst_n && rd_addr1 != XZR) begin
      if (wr_en && w_addr == rd_addr1) r_data1 = w_data;
      else                             r_data1 = regs[rd_addr1];
    end
  end

  always_comb begin
    r_data2 = '0;
    if (rst_n && rd_addr2 != XZR) begin
      if (wr_en && w_addr == rd_addr2) r_data2 = w_data;
      else                             r_data2 = regs[rd_addr2];
    end
  end

  // An operand arriving on the write-back bus this cycle is bypassed, so it
  // does not stall.
  function automatic logic hazard(input logic [ADDR_W-1:0] a);
    return busy[a] && (a != XZR) && !(RegWrite && w_addr == a);
  endfunction

  assign stall = (rd_use1 && hazard(rd_addr1)) || (rd_use2 && hazard(rd_addr2));

endmodule
